// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - start/stop/pause counter FSM with one-shot or periodic terminal count
// Optional tick prescaler enabled by defining CTRL_PRESCALE_EN.
module count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
`ifdef CTRL_PRESCALE_EN
  input  logic [3:0]       prescale,
`endif
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           cur_state, nxt_state;
  logic [WIDTH-1:0] lim_r, nxt_lim;
  logic             per_r, nxt_per;
  logic [WIDTH-1:0] nxt_q;
  logic             nxt_done, nxt_wrap;
  logic             tick;

`ifdef CTRL_PRESCALE_EN
  logic [3:0] pre_r, nxt_pre;
  logic [3:0] pcnt, nxt_pcnt;
  assign tick = (pcnt == pre_r);
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      q         <= '0;
      lim_r     <= '0;
      per_r     <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
`ifdef CTRL_PRESCALE_EN
      pre_r     <= 4'd0;
      pcnt      <= 4'd0;
`endif
    end else begin
      cur_state <= nxt_state;
      q         <= nxt_q;
      lim_r     <= nxt_lim;
      per_r     <= nxt_per;
      done      <= nxt_done;
      wrap      <= nxt_wrap;
`ifdef CTRL_PRESCALE_EN
      pre_r     <= nxt_pre;
      pcnt      <= nxt_pcnt;
`endif
    end
  end

  always_comb begin
    nxt_state = cur_state;
    nxt_q     = q;
    nxt_lim   = lim_r;
    nxt_per   = per_r;
    nxt_done  = 1'b0;
    nxt_wrap  = 1'b0;
`ifdef CTRL_PRESCALE_EN
    nxt_pre   = pre_r;
    nxt_pcnt  = pcnt;
`endif
    case (cur_state)
      IDLE: begin
        nxt_q = '0;
        if (start && !stop) begin
          nxt_state = RUN;
          nxt_lim   = limit;
          nxt_per   = periodic;
`ifdef CTRL_PRESCALE_EN
          nxt_pre   = prescale;
          nxt_pcnt  = 4'd0;
`endif
        end
      end
      RUN: begin
        if (stop) begin
          nxt_state = IDLE;
          nxt_q     = '0;
`ifdef CTRL_PRESCALE_EN
          nxt_pcnt  = 4'd0;
`endif
        end else if (pause) begin
          // Pause wins over a terminal tick: q and prescaler stay frozen.
          nxt_state = HOLD;
        end else if (tick) begin
`ifdef CTRL_PRESCALE_EN
          nxt_pcnt = 4'd0;
`endif
          if (q != lim_r) begin
            nxt_q = q + WIDTH'(1);
          end else if (per_r) begin
            nxt_q    = '0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_state = DONE;
            nxt_done  = 1'b1;
          end
        end else begin
`ifdef CTRL_PRESCALE_EN
          nxt_pcnt = pcnt + 4'd1;
`endif
        end
      end
      HOLD: begin
        if (stop) begin
          nxt_state = IDLE;
          nxt_q     = '0;
`ifdef CTRL_PRESCALE_EN
          nxt_pcnt  = 4'd0;
`endif
        end else if (!pause) begin
          nxt_state = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          nxt_state = IDLE;
          nxt_q     = '0;
`ifdef CTRL_PRESCALE_EN
          nxt_pcnt  = 4'd0;
`endif
        end else if (start) begin
          nxt_state = RUN;
          nxt_q     = '0;
          nxt_lim   = limit;
          nxt_per   = periodic;
`ifdef CTRL_PRESCALE_EN
          nxt_pre   = prescale;
          nxt_pcnt  = 4'd0;
`endif
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign busy  = (cur_state == RUN) || (cur_state == HOLD);
  assign state = cur_state;

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - table-driven and directed sequence checks for count_ctrl
module tb_count_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0;
  logic [3:0] limit = 4'd0;
  logic [3:0] q;
  logic       busy, done, wrap;
  logic [1:0] state;
`ifdef CTRL_PRESCALE_EN
  logic [3:0] prescale = 4'd0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int vn = 0;

  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_HOLD = 2'b10, S_DONE = 2'b11;

  typedef struct {
    logic       st, sp, pa, per;
    logic [3:0] lim;
    logic [3:0] eq;
    logic [1:0] es;
    logic       ed, ew;
  } vec_t;

  vec_t tv[$];

  count_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic),
`ifdef CTRL_PRESCALE_EN
    .prescale(prescale),
`endif
    .limit(limit), .q(q), .busy(busy), .done(done), .wrap(wrap), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, sp, pa, per, input logic [3:0] lim,
                              input logic [3:0] eq, input logic [1:0] es, input logic ed, ew);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.per = per; v.lim = lim;
    v.eq = eq; v.es = es; v.ed = ed; v.ew = ew;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @vec %0d: got %0d expected %0d", name, vn, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    start = v.st; stop = v.sp; pause = v.pa; periodic = v.per; limit = v.lim;
    @(posedge clk);
    #1;
    check("q", int'(q), int'(v.eq));
    check("state", int'(state), int'(v.es));
    check("done", int'(done), int'(v.ed));
    check("wrap", int'(wrap), int'(v.ew));
    check("busy", int'(busy), int'((v.es == S_RUN) || (v.es == S_HOLD)));
    vn++;
  endtask

  initial begin
    // One-shot limit 5
    tv.push_back(mk(1,0,0,0,5, 0,S_RUN,0,0));
    for (int i = 1; i <= 5; i++) tv.push_back(mk(0,0,0,0,5, 4'(i),S_RUN,0,0));
    tv.push_back(mk(0,0,0,0,5, 5,S_DONE,1,0));
    tv.push_back(mk(0,0,0,0,5, 5,S_DONE,0,0));
    // Periodic limit 3 restarted from DONE; limit/periodic/start changes while busy ignored
    tv.push_back(mk(1,0,0,1,3, 0,S_RUN,0,0));
    for (int i = 1; i <= 12; i++)
      tv.push_back(mk(logic'(i % 2), 0,0,0,7, 4'(i % 4), S_RUN, 0, logic'(i % 4 == 0)));
    tv.push_back(mk(0,0,0,0,7, 1,S_RUN,0,0));
    tv.push_back(mk(0,0,0,0,7, 2,S_RUN,0,0));
    tv.push_back(mk(1,1,0,0,7, 0,S_IDLE,0,0));
    tv.push_back(mk(0,0,0,0,7, 0,S_IDLE,0,0));
    // limit 0 one-shot
    tv.push_back(mk(1,0,0,0,0, 0,S_RUN,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,S_DONE,1,0));
    tv.push_back(mk(0,0,0,0,0, 0,S_DONE,0,0));
    // limit 2 latched, input changed to 7 mid-run
    tv.push_back(mk(1,0,0,0,2, 0,S_RUN,0,0));
    tv.push_back(mk(0,0,0,1,7, 1,S_RUN,0,0));
    tv.push_back(mk(0,0,0,1,7, 2,S_RUN,0,0));
    tv.push_back(mk(0,0,0,1,7, 2,S_DONE,1,0));
    tv.push_back(mk(0,0,0,0,7, 2,S_DONE,0,0));
    // pause on the terminal tick, then resume
    tv.push_back(mk(1,0,0,0,2, 0,S_RUN,0,0));
    tv.push_back(mk(0,0,0,0,2, 1,S_RUN,0,0));
    tv.push_back(mk(0,0,0,0,2, 2,S_RUN,0,0));
    tv.push_back(mk(0,0,1,0,2, 2,S_HOLD,0,0));
    tv.push_back(mk(0,0,0,0,2, 2,S_RUN,0,0));
    tv.push_back(mk(0,0,0,0,2, 2,S_DONE,1,0));
    tv.push_back(mk(0,1,0,0,2, 0,S_IDLE,0,0));
    // stop in HOLD beats pause and start
    tv.push_back(mk(1,0,0,0,5, 0,S_RUN,0,0));
    tv.push_back(mk(0,0,1,0,5, 0,S_HOLD,0,0));
    tv.push_back(mk(1,1,1,0,5, 0,S_IDLE,0,0));

    #8;
    check("rst_q", int'(q), 0);
    check("rst_state", int'(state), int'(S_IDLE));
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wrap", int'(wrap), 0);
    #2 reset = 1'b0;

    foreach (tv[i]) step(tv[i]);

    // Pause for 3 cycles at q=4, limit 9: ten RUN ticks to DONE
    step(mk(1,0,0,0,9, 0,S_RUN,0,0));
    for (int i = 1; i <= 4; i++) step(mk(0,0,0,0,9, 4'(i),S_RUN,0,0));
    for (int i = 0; i < 3; i++) step(mk(0,0,1,0,9, 4,S_HOLD,0,0));
    step(mk(0,0,0,0,9, 4,S_RUN,0,0));
    for (int i = 5; i <= 9; i++) step(mk(0,0,0,0,9, 4'(i),S_RUN,0,0));
    step(mk(0,0,0,0,9, 9,S_DONE,1,0));
    step(mk(0,1,0,0,9, 0,S_IDLE,0,0));

    // Full range, periodic limit 15
    step(mk(1,0,0,1,15, 0,S_RUN,0,0));
    for (int i = 1; i <= 15; i++) step(mk(0,0,0,1,15, 4'(i),S_RUN,0,0));
    step(mk(0,0,0,1,15, 0,S_RUN,0,1));
    step(mk(0,1,0,0,15, 0,S_IDLE,0,0));

    // Asynchronous reset between edges at q=6
    step(mk(1,0,0,0,9, 0,S_RUN,0,0));
    for (int i = 1; i <= 6; i++) step(mk(0,0,0,0,9, 4'(i),S_RUN,0,0));
    #2 reset = 1'b1;
    #1;
    check("async_q", int'(q), 0);
    check("async_state", int'(state), int'(S_IDLE));
    check("async_busy", int'(busy), 0);
    #1 reset = 1'b0;
    step(mk(0,0,0,0,9, 0,S_IDLE,0,0));
    step(mk(1,0,0,0,1, 0,S_RUN,0,0));
    step(mk(0,0,0,0,1, 1,S_RUN,0,0));
    step(mk(0,0,0,0,1, 1,S_DONE,1,0));

`ifdef CTRL_PRESCALE_EN
    // prescale 2, limit 2: q steps every third cycle, DONE on the ninth
    prescale = 4'd2;
    step(mk(1,0,0,0,2, 0,S_RUN,0,0));
    prescale = 4'd0;
    for (int k = 1; k <= 8; k++) step(mk(0,0,0,0,2, 4'(k / 3),S_RUN,0,0));
    step(mk(0,0,0,0,2, 2,S_DONE,1,0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
